// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: RISC-V immediate generator with a 2-entry output FIFO.
// The immediate is formed when an instruction is accepted and buffered with
// its sideband tag, so the downstream stage sees a registered result one
// cycle later.  in_ready is derived from registered state only.
// Optional feature: define IMMGEN_ILLEGAL_TRAP_EN to store and report an
// illegal-format flag per entry; otherwise imm_illegal is tied low.
module imm_gen_pipe #(
    parameter int XLEN  = 32,   // 32 or 64
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [2:0]       ImmSrc,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  ImmExt,
    output logic [TAG_W-1:0] out_tag,
    output logic             imm_illegal
);

    // The immediate is built at 64 bits and truncated, which makes the
    // U-type sign extension for XLEN=64 fall out naturally.
    logic [63:0]      imm_wide;
    logic [XLEN-1:0]  imm_calc;

    // FIFO storage and control
    logic [XLEN-1:0]  imm_q [2];
    logic [TAG_W-1:0] tag_q [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q,  count_d;
    logic             ready_q;
    logic             push, pop;

    // Opcode bits are never part of an immediate; the upper half of the
    // wide immediate is discarded when XLEN=32.
    logic             unused_bits;
    assign unused_bits = ^{instr[6:0], imm_wide};

    // Immediate decode by format; illegal formats produce zero.
    always_comb begin
        imm_wide = 64'd0;
        case (ImmSrc)
            3'b000: imm_wide = {{52{instr[31]}}, instr[31:20]};
            3'b001: imm_wide = {{52{instr[31]}}, instr[31:25], instr[11:7]};
            3'b010: imm_wide = {{52{instr[31]}}, instr[7], instr[30:25],
                                instr[11:8], 1'b0};
            3'b011: imm_wide = {{32{instr[31]}}, instr[31:12], 12'd0};
            3'b100: imm_wide = {{44{instr[31]}}, instr[19:12], instr[20],
                                instr[30:21], 1'b0};
            3'b101: begin
                if (XLEN == 64) imm_wide = {58'd0, instr[25:20]};
                else            imm_wide = {59'd0, instr[24:20]};
            end
            default: imm_wide = 64'd0;
        endcase
    end

    assign imm_calc = imm_wide[XLEN-1:0];

    assign in_ready  = ready_q && (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Next-state for pointers and occupancy; flush wins over push and pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push) wr_ptr_d = ~wr_ptr_q;
            if (pop)  rd_ptr_d = ~rd_ptr_q;
            if (push && !pop)      count_d = count_q + 2'd1;
            else if (pop && !push) count_d = count_q - 2'd1;
        end
    end

    // Control registers; ready_q keeps in_ready low until the first edge
    // after reset is released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            ready_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= 1'b1;
        end
    end

    // Entry storage: write the slot under the write pointer on a real push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                imm_q[i] <= '0;
                tag_q[i] <= '0;
            end
        end else if (push && !flush) begin
            imm_q[wr_ptr_q] <= imm_calc;
            tag_q[wr_ptr_q] <= in_tag;
        end
    end

    // Outputs are forced to zero whenever no entry is presented.
    assign ImmExt  = out_valid ? imm_q[rd_ptr_q] : '0;
    assign out_tag = out_valid ? tag_q[rd_ptr_q] : '0;

`ifdef IMMGEN_ILLEGAL_TRAP_EN
    logic ill_q [2];

    // Illegal-format flag travels with its entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ill_q[0] <= 1'b0;
            ill_q[1] <= 1'b0;
        end else if (push && !flush) begin
            ill_q[wr_ptr_q] <= ImmSrc[2] & ImmSrc[1];
        end
    end

    assign imm_illegal = out_valid ? ill_q[rd_ptr_q] : 1'b0;
`else
    assign imm_illegal = 1'b0;
`endif

endmodule
